// File: rtl/dmac_addr_pkg.sv
// Shared types and constants for the DMAC burst address generator.
// The optional 4 KiB burst split is selected with the DMAC_ADDR_4K_SPLIT_EN macro.
package dmac_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_ID = 2'd1,
    ST_ISSUE   = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  localparam int unsigned ID_MAX_W = 16;

  // Increment an ID held in the low 'width' bits, wrapping modulo 2**width.
  function automatic logic [ID_MAX_W-1:0] inc_id(input logic [ID_MAX_W-1:0] cur,
                                                 input int unsigned width);
    logic [ID_MAX_W-1:0] mask;
    mask = (ID_MAX_W'(1) << width) - ID_MAX_W'(1);
    return (cur + ID_MAX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/dmac_burst_len_calc.sv
// Combinational burst length: min(remaining, MAX_BURST_BEATS[, beats to 4 KiB page end]).
// The page-boundary limit exists only when DMAC_ADDR_4K_SPLIT_EN is defined.
module dmac_burst_len_calc #(
  parameter int unsigned MAX_BURST_BEATS = 16,
  parameter int unsigned LENGTH_WIDTH    = 24
`ifdef DMAC_ADDR_4K_SPLIT_EN
  , parameter int unsigned BEAT_BYTES_LOG2 = 3
`endif
) (
`ifdef DMAC_ADDR_4K_SPLIT_EN
  input  logic [11:0]           addr_lo,
`endif
  input  logic [LENGTH_WIDTH:0] remaining,
  output logic [7:0]            len_c,
  output logic                  last_c
);

  localparam int unsigned CW = (LENGTH_WIDTH + 1 > 13) ? LENGTH_WIDTH + 1 : 13;

  logic [CW-1:0] rem_w;
  logic [CW-1:0] max_w;
  logic [CW-1:0] beats;

  assign rem_w = CW'(remaining);
  assign max_w = CW'(MAX_BURST_BEATS);

`ifdef DMAC_ADDR_4K_SPLIT_EN
  logic [CW-1:0] to_4k;

  // Bytes left in the current page, converted to beats (always 1..4096 bytes).
  assign to_4k = CW'((13'h1000 - {1'b0, addr_lo}) >> BEAT_BYTES_LOG2);

  always_comb begin
    beats = (rem_w < max_w) ? rem_w : max_w;
    if (to_4k < beats) beats = to_4k;
  end
`else
  assign beats = (rem_w < max_w) ? rem_w : max_w;
`endif

  assign len_c  = 8'(beats - CW'(1));
  assign last_c = (beats == rem_w);

endmodule

// File: rtl/dmac_burst_addr_gen.sv
// DMAC AXI address-channel generator: splits a transfer into INCR bursts gated by ID slots.
// Define DMAC_ADDR_4K_SPLIT_EN to keep bursts from crossing 4 KiB boundaries.
module dmac_burst_addr_gen
  import dmac_addr_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = 3,
  parameter int unsigned BEAT_BYTES_LOG2 = 3,
  parameter int unsigned MAX_BURST_BEATS = 16,
  parameter int unsigned LENGTH_WIDTH    = 24
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_address,
  input  logic [LENGTH_WIDTH-1:0] req_length,
  input  logic                    enable,
  output logic                    enabled,
  output logic [ID_WIDTH-1:0]     id,
  input  logic [ID_WIDTH-1:0]     wait_id,
  input  logic                    sync_id,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [31:0]             addr,
  output logic [7:0]              len,
  output logic [2:0]              size,
  output logic [1:0]              burst,
  output logic [2:0]              prot,
  output logic [3:0]              cache,
  output logic                    burst_last
);

  localparam int unsigned RW = LENGTH_WIDTH + 1;

  state_e              state_q, state_d;
  logic [RW-1:0]       remaining_q, remaining_d;
  logic [31:0]         addr_d;
  logic [ID_WIDTH-1:0] id_d, id_inc;
  logic [7:0]          len_d;
  logic                last_d;
  logic                enabled_d;
  logic                accept_c;
  logic                hs_c;
  logic [8:0]          beats;
  logic [7:0]          calc_len_c;
  logic                calc_last_c;

  assign size  = 3'(BEAT_BYTES_LOG2);
  assign burst = AXI_BURST_INCR;
  assign prot  = AXI_PROT_DEFAULT;
  assign cache = AXI_CACHE_DEFAULT;

  dmac_burst_len_calc #(
    .MAX_BURST_BEATS (MAX_BURST_BEATS),
    .LENGTH_WIDTH    (LENGTH_WIDTH)
`ifdef DMAC_ADDR_4K_SPLIT_EN
    , .BEAT_BYTES_LOG2 (BEAT_BYTES_LOG2)
`endif
  ) u_len_calc (
`ifdef DMAC_ADDR_4K_SPLIT_EN
    .addr_lo   (addr[11:0]),
`endif
    .remaining (remaining_q),
    .len_c     (calc_len_c),
    .last_c    (calc_last_c)
  );

  assign accept_c = req_valid & req_ready & enable & enabled;
  assign hs_c     = addr_valid & addr_ready;
  assign beats    = {1'b0, len} + 9'd1;
  assign id_inc   = ID_WIDTH'(inc_id(ID_MAX_W'(id), ID_WIDTH));

  // Next-state and datapath updates; len/burst_last latch on entry to ISSUE so they hold through it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr;
    remaining_d = remaining_q;
    id_d        = id;
    len_d       = len;
    last_d      = burst_last;
    enabled_d   = enable ? 1'b1 : (addr_valid ? enabled : 1'b0);

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d     = ST_WAIT_ID;
          addr_d      = req_address;
          remaining_d = RW'(req_length) + RW'(1);
        end
      end
      ST_WAIT_ID: begin
        if (!enabled) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (id != wait_id) begin
          state_d = ST_ISSUE;
          len_d   = calc_len_c;
          last_d  = calc_last_c;
        end
      end
      ST_ISSUE: begin
        if (hs_c) begin
          addr_d      = addr + (32'(beats) << BEAT_BYTES_LOG2);
          remaining_d = remaining_q - RW'(beats);
          id_d        = id_inc;
          state_d     = burst_last ? ST_IDLE : ST_WAIT_ID;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_ISSUE && sync_id && id != wait_id) id_d = id_inc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_ready   <= 1'b1;
      addr_valid  <= 1'b0;
      enabled     <= 1'b0;
      id          <= '0;
      addr        <= '0;
      remaining_q <= '0;
      len         <= '0;
      burst_last  <= 1'b0;
    end else begin
      req_ready   <= (state_d == ST_IDLE);
      addr_valid  <= (state_d == ST_ISSUE);
      enabled     <= enabled_d;
      id          <= id_d;
      addr        <= addr_d;
      remaining_q <= remaining_d;
      len         <= len_d;
      burst_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_dmac_burst_addr_gen.sv
// Scoreboard bench for dmac_burst_addr_gen: a transfer-level model predicts each burst.
module tb_dmac_burst_addr_gen;

  localparam int unsigned BB = 3;
  localparam int unsigned MB = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_address = '0;
  logic [23:0] req_length = '0;
  logic        enable = 1'b0;
  logic        enabled;
  logic [2:0]  id;
  logic [2:0]  wait_id;
  logic        sync_id = 1'b0;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [2:0]  prot;
  logic [3:0]  cache;
  logic        burst_last;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   hs_cnt = 0;
  int   sync_cnt = 0;
  logic [2:0] model_id;
  int   wmode = 0;
  int   rmode = 0;
  logic [2:0] wait_abs = '0;
  logic stall = 1'b0;
  logic ready_rnd = 1'b1;

  dmac_burst_addr_gen #(
    .ID_WIDTH(3), .BEAT_BYTES_LOG2(BB), .MAX_BURST_BEATS(MB), .LENGTH_WIDTH(24)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_length(req_length),
    .enable(enable), .enabled(enabled),
    .id(id), .wait_id(wait_id), .sync_id(sync_id),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .len(len), .size(size),
    .burst(burst), .prot(prot), .cache(cache),
    .burst_last(burst_last)
  );

  always #5 clk = ~clk;

  // Consumer side: wait_id tracks the model ID with random slot stalls; ready is random or forced.
  assign model_id   = 3'(hs_cnt + sync_cnt);
  assign wait_id    = (wmode == 0) ? (stall ? model_id : 3'(model_id + 3'd3)) :
                      (wmode == 1) ? model_id :
                      (wmode == 2) ? 3'(model_id + 3'd1) : wait_abs;
  assign addr_ready = (rmode == 0) ? ready_rnd : (rmode == 2);

  always @(posedge clk) begin
    #1;
    stall     = ($urandom_range(0, 9) == 0);
    ready_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: split a transfer into bursts using the beat-count rules directly.
  task automatic push_model(input logic [31:0] a0, input int unsigned len_m1);
    logic [31:0] a;
    int unsigned rem, b;
    exp_t e;
    a = a0;
    rem = len_m1 + 1;
    while (rem > 0) begin
      b = (rem < MB) ? rem : MB;
`ifdef DMAC_ADDR_4K_SPLIT_EN
      begin
        int unsigned pb;
        pb = (4096 - int'(a % 4096)) / (1 << BB);
        if (pb < b) b = pb;
      end
`endif
      e.addr = a;
      e.len  = 8'(b - 1);
      e.last = (b == rem);
      exp_q.push_back(e);
      a = a + 32'(b * (1 << BB));
      rem -= b;
    end
  endtask

  task automatic issue(input logic [31:0] a, input int unsigned len_m1);
    bit acc;
    int n;
    req_address = a;
    req_length  = 24'(len_m1);
    req_valid   = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      acc = req_ready && enabled && enable;
      if (acc) push_model(a, len_m1);
      tick();
      n++;
    end
    req_valid = 1'b0;
    if (!acc) timeout("req_accept");
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && req_ready) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!addr_valid && n < 200) begin
      tick();
      n++;
    end
    if (!addr_valid) timeout(name);
  endtask

  // Monitor: compare each burst presented on a handshake against the scoreboard.
  always @(negedge clk) begin
    if (!resetn) begin
      hs_cnt = 0;
      exp_q.delete();
    end else if (addr_valid && addr_ready) begin
      check("id_at_handshake", 64'(id), 64'(model_id));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_burst: got addr 0x%0h len %0d expected none", addr, len);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("burst_addr_len_last", 64'({addr, len, burst_last}), 64'(e));
      end
      hs_cnt = hs_cnt + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit held;
    repeat (3) tick();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_addr_valid", 64'(addr_valid), 64'd0);
    check("rst_enabled", 64'(enabled), 64'd0);
    check("rst_id", 64'(id), 64'd0);
    check("rst_burst_last", 64'(burst_last), 64'd0);
    check("const_fields", 64'({size, burst, prot, cache}), 64'({3'd3, 2'b01, 3'b000, 4'b0011}));
    resetn = 1'b1;
    enable = 1'b1;
    tick();
    tick();
    check("enabled_rise", 64'(enabled), 64'd1);

    // Aligned multi-burst transfer, then the page-straddling transfer.
    issue(32'h0000_1000, 39);
    drain("drain_1000");
    check("req_ready_after_xfer", 64'(req_ready), 64'd1);
    issue(32'h0000_0FC0, 15);
    drain("drain_0fc0");

    // All ID slots in use: no burst until the consumer moves wait_id.
    wmode = 1;
    issue(32'h0000_2000, 3);
    held = 1'b1;
    repeat (10) begin
      if (addr_valid) held = 1'b0;
      tick();
    end
    check("slots_full_no_valid", 64'(held), 64'd1);
    wmode = 2;
    drain("drain_slot_release");
    wmode = 0;

    // Dropping enable while a burst is pending keeps enabled until the handshake.
    rmode = 1;
    issue(32'h0000_3000, 7);
    wait_valid("valid_for_enable_hold");
    enable = 1'b0;
    repeat (5) begin
      tick();
      check("enabled_held", 64'(enabled), 64'd1);
    end
    rmode = 2;
    tick();
    tick();
    check("enabled_dropped", 64'(enabled), 64'd0);
    check("valid_after_disable", 64'(addr_valid), 64'd0);
    rmode = 0;
    enable = 1'b1;
    tick();
    tick();

    // Reset asserted mid-ISSUE takes effect immediately.
    rmode = 1;
    issue(32'h0000_4000, 47);
    wait_valid("valid_before_reset");
    resetn = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_addr_valid", 64'(addr_valid), 64'd0);
    check("midrst_enabled", 64'(enabled), 64'd0);
    check("midrst_id", 64'(id), 64'd0);
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_burst_last", 64'(burst_last), 64'd0);
    tick();
    tick();
    sync_cnt = 0;
    resetn = 1'b1;
    rmode = 0;
    tick();
    tick();

    // sync_id in IDLE advances id without issuing a burst.
    wmode = 3;
    wait_abs = 3'd5;
    repeat (2) begin
      sync_id = 1'b1;
      tick();
      sync_id = 1'b0;
      sync_cnt++;
    end
    check("sync_id_to_2", 64'(id), 64'd2);
    sync_id = 1'b1;
    tick();
    sync_id = 1'b0;
    sync_cnt++;
    check("sync_id_to_3", 64'(id), 64'd3);
    check("sync_no_valid", 64'(addr_valid), 64'd0);
    wmode = 0;
    issue(32'h0000_5008, 20);
    drain("drain_after_reset");

    // Randomized transfers including page-edge and 32-bit wrap starting points.
    for (int i = 0; i < 25; i++) begin
      logic [31:0] a;
      int unsigned sel, l;
      sel = $urandom_range(0, 4);
      a = $urandom & 32'hFFFF_FFF8;
      if (sel == 1) a = (a & 32'hFFFF_F000) | 32'h0000_0F80 | ($urandom & 32'h78);
      if (sel == 2) a = 32'hFFFF_FF00 | ($urandom & 32'hF8);
      l = (sel == 3) ? 0 : $urandom_range(0, 63);
      issue(a, l);
      drain("drain_random");
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
